// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer
//   Consumes the gpu pixel stream, which has no backpressure. Each in-range
//   pixel is converted to a linear frame-buffer word address (y*SCREEN_WIDTH+x).
//   Its colour is packed into one {r,g,b} word. The address/data pair is queued
//   in a small FIFO. Queued writes are issued one at a time over a req/ack
//   memory port.
//   A pixel is dropped and counted when the FIFO is full or the pixel is off
//   screen. Only a drop caused by fullness sets the sticky overflow flag.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   data_avail_i         x_i/y_i/r_i/g_i/b_i carry a pixel this cycle
//   x_i, y_i             pixel coordinates
//   r_i, g_i, b_i        pixel colour channels
//   mem_req_o            write request, held until mem_ack_i
//   mem_addr_o           word address of the FIFO head (0 when idle)
//   mem_data_o           {r,g,b} of the FIFO head (0 when idle)
//   mem_ack_i            write accepted this cycle (ignored when idle)
//   fifo_count_o         entries currently queued
//   overflow_o           sticky: a valid pixel was dropped on a full FIFO
//   drop_count_o         dropped pixels, saturating at 16'hFFFF
//
// Memory handshake: mem_req_o is raised with mem_addr_o/mem_data_o and all
// three stay constant until the first rising edge at which mem_ack_i=1. That
// edge completes the write and pops the FIFO head. If the FIFO is still
// non-empty after that edge, the next write is presented in the following
// cycle.
module gpu_pixel_writer #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 9,
  parameter int CHANNEL_BITS  = 8,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_BITS     = 19,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_avail_i,
  input  logic [WIDTH_BITS-1:0]         x_i,
  input  logic [HEIGHT_BITS-1:0]        y_i,
  input  logic [CHANNEL_BITS-1:0]       r_i,
  input  logic [CHANNEL_BITS-1:0]       g_i,
  input  logic [CHANNEL_BITS-1:0]       b_i,
  output logic                          mem_req_o,
  output logic [ADDR_BITS-1:0]          mem_addr_o,
  output logic [3*CHANNEL_BITS-1:0]     mem_data_o,
  input  logic                          mem_ack_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic [15:0]                   drop_count_o
);

  localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam int DATA_BITS  = 3 * CHANNEL_BITS;
  localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;

  localparam logic [WIDTH_BITS:0]  X_LIMIT  = (WIDTH_BITS + 1)'(SCREEN_WIDTH);
  localparam logic [HEIGHT_BITS:0] Y_LIMIT  = (HEIGHT_BITS + 1)'(SCREEN_HEIGHT);
  localparam logic [CNT_BITS-1:0]  CNT_FULL = CNT_BITS'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                state, next_state;
  logic [CNT_BITS-1:0]   count, count_next;
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [ENTRY_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENTRY_BITS-1:0] head;

  logic                  in_range, full, push, pop;
  logic [ADDR_BITS-1:0]  push_addr;
  logic [DATA_BITS-1:0]  push_data;
  logic                  drop_any, drop_full;
  logic [15:0]           drop_count;
  logic                  overflow;

  // Pixel qualification and address generation
  assign in_range = ({1'b0, x_i} < X_LIMIT) && ({1'b0, y_i} < Y_LIMIT);

  // Both operands are zero-extended to the full address width before the
  // multiply. The low ADDR_BITS of a product depend only on the low ADDR_BITS
  // of its operands, so this matches a wider multiply-add cut to ADDR_BITS at
  // the end. Coordinates are never narrowed first.
  assign push_addr = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(x_i);
  assign push_data = {r_i, g_i, b_i};

  // FIFO control
  assign full = (count == CNT_FULL);
  assign pop  = (state == REQ) && mem_ack_i;
  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign push = data_avail_i && in_range && (!full || pop);

  assign drop_any  = data_avail_i && !push;
  assign drop_full = data_avail_i && in_range && !push;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_BITS'(1);
      2'b01:   count_next = count - CNT_BITS'(1);
      default: count_next = count;
    endcase
  end

  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      // Depth is a power of two, so the pointers wrap by overflowing.
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
    end
  end

  // The storage array holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {push_addr, push_data};
  end

  // Drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (drop_any && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (drop_full) overflow <= 1'b1;
    end
  end

  // Write FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Write FSM: next state
  // IDLE looks at the registered count. A pixel pushed at edge N therefore
  // raises the request after edge N+1.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != '0) next_state = REQ;
      REQ:     if (mem_ack_i && (count_next == '0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (state == REQ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = head[ENTRY_BITS-1:DATA_BITS];
      mem_data_o = head[DATA_BITS-1:0];
    end
  end

  assign fifo_count_o = count;
  assign overflow_o   = overflow;
  assign drop_count_o = drop_count;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
module tb_gpu_pixel_writer;

  localparam int W = 43;   // {addr[18:0], data[23:0]}

  logic        tb_clk = 1'b0;
  logic        rst;
  logic        data_avail_i;
  logic [9:0]  x_i;
  logic [8:0]  y_i;
  logic [7:0]  r_i, g_i, b_i;
  logic        mem_req_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        mem_ack_i;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;
  logic [15:0] drop_count_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  gpu_pixel_writer dut (
    .clk(tb_clk), .rst(rst), .data_avail_i(data_avail_i),
    .x_i(x_i), .y_i(y_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .fifo_count_o(fifo_count_o),
    .overflow_o(overflow_o), .drop_count_o(drop_count_o)
  );

  // clock / reset
  always #5 tb_clk = ~tb_clk;

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_avail_i = 1'b0; mem_ack_i = 1'b0;
    x_i = '0; y_i = '0; r_i = '0; g_i = '0; b_i = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // driver
  task automatic drive(input logic av, input logic [9:0] x, input logic [8:0] y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic ack);
    data_avail_i = av; x_i = x; y_i = y; r_i = r; g_i = g; b_i = b; mem_ack_i = ack;
  endtask

  // pattern pixel i (always on screen for the i values used)
  function automatic logic [9:0] pix_x(input int i); return 10'((i * 7 + 1) % 640); endfunction
  function automatic logic [8:0] pix_y(input int i); return 9'((i + 10) % 480); endfunction

  task automatic drive_pix(input int i, input logic ack);
    drive(1'b1, pix_x(i), pix_y(i), 8'(i), 8'(i + 64), 8'(i + 128), ack);
  endtask

  function automatic logic [W-1:0] pix_entry(input int i);
    logic [18:0] a;
    a = 19'(int'(pix_y(i)) * 640 + int'(pix_x(i)));
    return {a, 8'(i), 8'(i + 64), 8'(i + 128)};
  endfunction

  // comparison
  task automatic check(input string name, input logic e_req, input logic [18:0] e_addr,
                       input logic [23:0] e_data, input logic [3:0] e_cnt,
                       input logic e_ovf, input logic [15:0] e_drop);
    n_vec++;
    if ({mem_req_o, mem_addr_o, mem_data_o, fifo_count_o, overflow_o, drop_count_o} !==
        {e_req, e_addr, e_data, e_cnt, e_ovf, e_drop}) begin
      n_miss++;
      $display("FAIL %s: got req=%0b addr=%0d data=%h cnt=%0d ovf=%0b drop=%0d; want req=%0b addr=%0d data=%h cnt=%0d ovf=%0b drop=%0d",
               name, mem_req_o, mem_addr_o, mem_data_o, fifo_count_o, overflow_o, drop_count_o,
               e_req, e_addr, e_data, e_cnt, e_ovf, e_drop);
    end
  endtask

  typedef struct {
    logic        av;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  r, g, b;
    logic        ack;
    logic        e_req;
    logic [18:0] e_addr;
    logic [23:0] e_data;
    logic [3:0]  e_cnt;
    logic        e_ovf;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // inputs applied for one edge, then expected outputs after that edge
    vecs[0]  = '{1, 3,   2,   'h11, 'h22, 'h33, 0,  0, 0,      0,         1, 0, 0};
    vecs[1]  = '{0, 0,   0,   0,    0,    0,    0,  1, 1283,   'h112233,  1, 0, 0};
    vecs[2]  = '{0, 0,   0,   0,    0,    0,    0,  1, 1283,   'h112233,  1, 0, 0};
    vecs[3]  = '{0, 0,   0,   0,    0,    0,    1,  0, 0,      0,         0, 0, 0};
    vecs[4]  = '{0, 0,   0,   0,    0,    0,    0,  0, 0,      0,         0, 0, 0};
    vecs[5]  = '{1, 640, 0,   'haa, 'hbb, 'hcc, 0,  0, 0,      0,         0, 0, 1};
    vecs[6]  = '{1, 0,   480, 'haa, 'hbb, 'hcc, 0,  0, 0,      0,         0, 0, 2};
    vecs[7]  = '{0, 0,   0,   0,    0,    0,    0,  0, 0,      0,         0, 0, 2};
    vecs[8]  = '{1, 639, 479, 'hff, 'h00, 'h80, 0,  0, 0,      0,         1, 0, 2};
    vecs[9]  = '{0, 0,   0,   0,    0,    0,    0,  1, 307199, 'hff0080,  1, 0, 2};
    vecs[10] = '{0, 0,   0,   0,    0,    0,    1,  0, 0,      0,         0, 0, 2};
    vecs[11] = '{0, 0,   0,   0,    0,    0,    1,  0, 0,      0,         0, 0, 2};
    vecs[12] = '{1, 0,   479, 'h01, 'h02, 'h03, 0,  0, 0,      0,         1, 0, 2};
    vecs[13] = '{1, 5,   1,   'h0a, 'h0b, 'h0c, 0,  1, 306560, 'h010203,  2, 0, 2};
    vecs[14] = '{0, 0,   0,   0,    0,    0,    1,  1, 645,    'h0a0b0c,  1, 0, 2};
    vecs[15] = '{0, 0,   0,   0,    0,    0,    1,  0, 0,      0,         0, 0, 2};

    do_reset();
    check("reset", 0, 0, 0, 0, 0, 0);

    // single write, out-of-range drops, corner address, back-to-back pair
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].av, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].ack);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_data,
            vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_drop);
    end

    // burst of 12 with no ack: 8 stored, 4 dropped for fullness
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_pix(i, 1'b0);
      if (i < 8) exp_q.push_back(pix_entry(i));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    check("burst_full", 1, exp_q[0][W-1:24], exp_q[0][23:0], 8, 1, 4);
    mem_ack_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("burst_drain%0d", k), 1, e[W-1:24], e[23:0], 4'(8 - k), 1, 4);
      step();
    end
    mem_ack_i = 1'b0;
    check("burst_idle", 0, 0, 0, 0, 1, 4);

    // full FIFO streaming with ack every cycle: no drops, count pinned at 8
    do_reset();
    check("reset_clear", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive_pix(i, 1'b0);
      exp_q.push_back(pix_entry(i));
      step();
    end
    for (int j = 0; j < 10; j++) begin
      drive_pix(100 + j, 1'b1);
      check($sformatf("stream_head%0d", j), 1, exp_q[0][W-1:24], exp_q[0][23:0], 8, 0, 0);
      void'(exp_q.pop_front());
      exp_q.push_back(pix_entry(100 + j));
      step();
      check($sformatf("stream_cnt%0d", j), 1, exp_q[0][W-1:24], exp_q[0][23:0], 8, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("stream_drain%0d", k), 1, e[W-1:24], e[23:0], 4'(8 - k), 0, 0);
      step();
    end
    mem_ack_i = 1'b0;
    check("stream_idle", 0, 0, 0, 0, 0, 0);

    // reset while a request is outstanding with 5 queued
    do_reset();
    drive(1, 700, 0, 0, 0, 0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive_pix(i, 1'b0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    check("pre_rst", 1, pix_entry(0)[W-1:24], pix_entry(0)[23:0], 5, 0, 1);
    rst = 1'b1; mem_ack_i = 1'b1;
    step();
    check("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    check("post_rst_ack", 0, 0, 0, 0, 0, 0);
    drive(1, 10, 20, 'h5a, 'ha5, 'h3c, 1'b0);
    step();
    check("post_rst_push", 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    step();
    check("post_rst_req", 1, 12810, 24'h5aa53c, 1, 0, 0);
    mem_ack_i = 1'b1;
    step();
    check("post_rst_done", 0, 0, 0, 0, 0, 0);
    mem_ack_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
